// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel pipeline: pattern encoding,
// colour-bar palette and default 1280x1024 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        BARS    = 2'd1,
        CHECKER = 2'd2,
        BOX     = 2'd3
    } pattern_e;

    localparam logic [11:0] BAR_WHITE   = 12'hFFF;
    localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [11:0] BAR_CYAN    = 12'h0FF;
    localparam logic [11:0] BAR_GREEN   = 12'h0F0;
    localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [11:0] BAR_RED     = 12'hF00;
    localparam logic [11:0] BAR_BLUE    = 12'h00F;
    localparam logic [11:0] BAR_BLACK   = 12'h000;

    localparam int H_DISPLAY = 1280;
    localparam int H_FRONT   = 48;
    localparam int H_SYNC    = 112;
    localparam int H_BACK    = 248;
    localparam int V_DISPLAY = 1024;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 38;
    localparam int BOX_SIZE_DEFAULT = 64;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one step per qualifying frame, reflecting off the
// display edges so the box always stays fully on screen.
module vga_box_mover #(
    parameter int HD       = 1280,
    parameter int VD       = 1024,
    parameter int BOX_SIZE = 64,
    parameter int XW       = 11,
    parameter int YW       = 11
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          step_i,
    output logic [XW-1:0] box_x_o,
    output logic [YW-1:0] box_y_o
);

    localparam logic [XW-1:0] X_LIM = XW'(HD - BOX_SIZE);
    localparam logic [YW-1:0] Y_LIM = YW'(VD - BOX_SIZE);

    logic [XW-1:0] box_x_q, box_x_d;
    logic [YW-1:0] box_y_q, box_y_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;

    // Next position: reflect at the far edge, bounce back to 1 at the origin.
    always_comb begin
        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;
        if (step_i) begin
            if (dir_x_q && (box_x_q == X_LIM)) begin
                dir_x_d = 1'b0;
                box_x_d = box_x_q - XW'(1);
            end else if (!dir_x_q && (box_x_q == '0)) begin
                dir_x_d = 1'b1;
                box_x_d = XW'(1);
            end else if (dir_x_q) begin
                box_x_d = box_x_q + XW'(1);
            end else begin
                box_x_d = box_x_q - XW'(1);
            end

            if (dir_y_q && (box_y_q == Y_LIM)) begin
                dir_y_d = 1'b0;
                box_y_d = box_y_q - YW'(1);
            end else if (!dir_y_q && (box_y_q == '0)) begin
                dir_y_d = 1'b1;
                box_y_d = YW'(1);
            end else if (dir_y_q) begin
                box_y_d = box_y_q + YW'(1);
            end else begin
                box_y_d = box_y_q - YW'(1);
            end
        end else begin
            box_x_d = box_x_q;
            box_y_d = box_y_q;
        end
    end

    // Position and direction registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign box_x_o = box_x_q;
    assign box_y_o = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source driven by the VGA timing counters; the RGB output
// is registered to line up with the generator's registered sync outputs.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int HSYNC_BITS = 11,
    parameter int VSYNC_BITS = 11,
    parameter int HD         = H_DISPLAY,
    parameter int HF         = H_FRONT,
    parameter int HR         = H_SYNC,
    parameter int HB         = H_BACK,
    parameter int VD         = V_DISPLAY,
    parameter int VF         = V_FRONT,
    parameter int VR         = V_SYNC,
    parameter int VB         = V_BACK,
    parameter int BOX_SIZE   = BOX_SIZE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [HSYNC_BITS-1:0] hcount,
    input  logic [VSYNC_BITS-1:0] vcount,
    input  logic [1:0]            mode_i,
    input  logic [11:0]           color_i,
    output logic [11:0]           rgb_o,
    output logic [1:0]            mode_o,
    output logic                  frame_start_o
);

    localparam logic [HSYNC_BITS-1:0] HMAX_C     = HSYNC_BITS'(HD + HF + HR + HB - 1);
    localparam logic [HSYNC_BITS-1:0] HOFS_C     = HSYNC_BITS'(HR + HB);
    localparam logic [HSYNC_BITS-1:0] HEND_C     = HSYNC_BITS'(HR + HB + HD);
    localparam logic [VSYNC_BITS-1:0] VMAX_C     = VSYNC_BITS'(VD + VF + VR + VB - 1);
    localparam logic [VSYNC_BITS-1:0] VOFS_C     = VSYNC_BITS'(VR + VB);
    localparam logic [VSYNC_BITS-1:0] VEND_C     = VSYNC_BITS'(VR + VB + VD);
    localparam logic [HSYNC_BITS-1:0] BAR_LAST_C = HSYNC_BITS'(HD / 8 - 1);
    localparam logic [HSYNC_BITS-1:0] BOX_W_C    = HSYNC_BITS'(BOX_SIZE);
    localparam logic [VSYNC_BITS-1:0] BOX_H_C    = VSYNC_BITS'(BOX_SIZE);

    pattern_e                  mode_q, mode_d;
    logic [11:0]               rgb_q, rgb_d;
    logic                      frame_start_q;
    logic [HSYNC_BITS-1:0]     bar_pix_q, bar_pix_d;
    logic [2:0]                bar_idx_q, bar_idx_d;

    logic                      active_s;
    logic                      fb_s;
    logic                      step_s;
    logic                      in_box_s;
    logic [HSYNC_BITS-1:0]     x_s;
    logic [VSYNC_BITS-1:0]     y_s;
    logic [HSYNC_BITS-1:0]     pix_cur_s;
    logic [2:0]                idx_cur_s;
    logic [HSYNC_BITS-1:0]     box_x_s;
    logic [VSYNC_BITS-1:0]     box_y_s;

    assign active_s = (hcount >= HOFS_C) && (hcount < HEND_C) &&
                      (vcount >= VOFS_C) && (vcount < VEND_C);
    assign x_s      = hcount - HOFS_C;
    assign y_s      = vcount - VOFS_C;
    assign fb_s     = (hcount == HMAX_C) && (vcount == VMAX_C);
    assign step_s   = fb_s && (mode_q == BOX);
    assign in_box_s = (x_s >= box_x_s) && (x_s < (box_x_s + BOX_W_C)) &&
                      (y_s >= box_y_s) && (y_s < (box_y_s + BOX_H_C));

    vga_box_mover #(
        .HD       (HD),
        .VD       (VD),
        .BOX_SIZE (BOX_SIZE),
        .XW       (HSYNC_BITS),
        .YW       (VSYNC_BITS)
    ) u_box_mover (
        .clk     (clk),
        .arstn   (arstn),
        .step_i  (step_s),
        .box_x_o (box_x_s),
        .box_y_o (box_y_s)
    );

    // Bar tracking: x==0 forces the pair to zero for the pixel being shown, so
    // the bar index never needs a divide by the bar width.
    always_comb begin
        pix_cur_s = bar_pix_q;
        idx_cur_s = bar_idx_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (active_s && (x_s == '0)) begin
            pix_cur_s = '0;
            idx_cur_s = 3'd0;
        end else begin
            pix_cur_s = bar_pix_q;
            idx_cur_s = bar_idx_q;
        end
        if (active_s) begin
            if (pix_cur_s == BAR_LAST_C) begin
                bar_pix_d = '0;
                bar_idx_d = (idx_cur_s == 3'd7) ? 3'd7 : (idx_cur_s + 3'd1);
            end else begin
                bar_pix_d = pix_cur_s + HSYNC_BITS'(1);
                bar_idx_d = idx_cur_s;
            end
        end else begin
            bar_pix_d = bar_pix_q;
            bar_idx_d = bar_idx_q;
        end
    end

    // Pattern select and frame-boundary mode latch.
    always_comb begin
        rgb_d  = 12'h000;
        mode_d = mode_q;
        if (fb_s) begin
            mode_d = pattern_e'(mode_i);
        end else begin
            mode_d = mode_q;
        end
        if (active_s) begin
            case (mode_q)
                SOLID:   rgb_d = color_i;
                BARS:    rgb_d = bar_colour(idx_cur_s);
                CHECKER: rgb_d = (x_s[5] ^ y_s[5]) ? color_i : 12'h000;
                BOX:     rgb_d = in_box_s ? color_i : 12'h000;
                default: rgb_d = 12'h000;
            endcase
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Output, mode and bar-counter registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rgb_q         <= 12'h000;
            mode_q        <= SOLID;
            frame_start_q <= 1'b0;
            bar_pix_q     <= '0;
            bar_idx_q     <= 3'd0;
        end else begin
            rgb_q         <= rgb_d;
            mode_q        <= mode_d;
            frame_start_q <= fb_s;
            bar_pix_q     <= bar_pix_d;
            bar_idx_q     <= bar_idx_d;
        end
    end

    assign rgb_o         = rgb_q;
    assign mode_o        = mode_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with reduced 160x120 timing.
module tb_vga_pattern_gen;

    localparam int HOFS = 10;
    localparam int VOFS = 5;
    localparam int HMAX = 171;
    localparam int VMAX = 125;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic [1:0]  mode_i = 2'd0;
    logic [11:0] color_i = 12'h000;
    logic [11:0] rgb_o;
    logic [1:0]  mode_o;
    logic        frame_start_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cur_mode = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] color;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [0:19];

    vga_pattern_gen #(
        .HSYNC_BITS (11), .VSYNC_BITS (11),
        .HD (160), .HF (2), .HR (4), .HB (6),
        .VD (120), .VF (1), .VR (2), .VB (3),
        .BOX_SIZE (16)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .hcount        (hcount),
        .vcount        (vcount),
        .mode_i        (mode_i),
        .color_i       (color_i),
        .rgb_o         (rgb_o),
        .mode_o        (mode_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %03h expected %03h", name, act, exp);
    endtask

    task automatic drive(input int h, input int v);
        hcount = 11'(h);
        vcount = 11'(v);
        @(posedge clk);
        #1;
    endtask

    // Sweep the line from hcount 0 so bar counters see x==0, then check x.
    task automatic check_pix(input string name, input int x, input int y, input logic [11:0] exp);
        for (int h = 0; h <= x + HOFS; h++) drive(h, y + VOFS);
        chk(name, rgb_o, exp);
    endtask

    task automatic fb();
        drive(HMAX, VMAX);
    endtask

    task automatic set_mode(input int m);
        mode_i = 2'(m);
        fb();
        chk("set_mode_o", {10'd0, mode_o}, 12'(m));
        chk("set_mode_fs", {11'd0, frame_start_o}, 12'h001);
        cur_mode = m;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 12'hABC, 0,   0,   12'hABC};
        vecs[1]  = '{2'd0, 12'hABC, 159, 119, 12'hABC};
        vecs[2]  = '{2'd1, 12'h000, 0,   0,   12'hFFF};
        vecs[3]  = '{2'd1, 12'h000, 19,  0,   12'hFFF};
        vecs[4]  = '{2'd1, 12'h000, 20,  0,   12'hFF0};
        vecs[5]  = '{2'd1, 12'h000, 79,  0,   12'h0F0};
        vecs[6]  = '{2'd1, 12'h000, 100, 7,   12'hF00};
        vecs[7]  = '{2'd1, 12'h000, 159, 0,   12'h000};
        vecs[8]  = '{2'd1, 12'h000, 20,  50,  12'hFF0};
        vecs[9]  = '{2'd1, 12'h000, 130, 50,  12'h00F};
        vecs[10] = '{2'd1, 12'h000, 159, 50,  12'h000};
        vecs[11] = '{2'd2, 12'h0F0, 0,   0,   12'h000};
        vecs[12] = '{2'd2, 12'h0F0, 32,  0,   12'h0F0};
        vecs[13] = '{2'd2, 12'h0F0, 32,  32,  12'h000};
        vecs[14] = '{2'd2, 12'h0F0, 0,   32,  12'h0F0};
        vecs[15] = '{2'd2, 12'h0F0, 63,  64,  12'h0F0};
        vecs[16] = '{2'd3, 12'h5A3, 0,   0,   12'h5A3};
        vecs[17] = '{2'd3, 12'h5A3, 15,  15,  12'h5A3};
        vecs[18] = '{2'd3, 12'h5A3, 16,  0,   12'h000};
        vecs[19] = '{2'd3, 12'h5A3, 0,   16,  12'h000};

        // Reset held while counters run, including a frame boundary.
        mode_i  = 2'd1;
        color_i = 12'hFFF;
        drive(20, 20);
        for (int h = 160; h <= HMAX; h++) drive(h, VMAX);
        drive(0, 0);
        chk("rst_rgb", rgb_o, 12'h000);
        chk("rst_mode", {10'd0, mode_o}, 12'h000);
        chk("rst_fs", {11'd0, frame_start_o}, 12'h000);
        mode_i  = 2'd0;
        color_i = 12'h000;
        arstn   = 1'b1;
        check_pix("first_pixel_zero", 0, 0, 12'h000);

        // SOLID, blanking edges, mid-frame mode request.
        color_i = 12'hABC;
        check_pix("solid_abc", 1, 0, 12'hABC);
        drive(5, 10);    chk("hblank_sync", rgb_o, 12'h000);
        drive(170, 10);  chk("hblank_right", rgb_o, 12'h000);
        drive(169, 10);  chk("last_active", rgb_o, 12'hABC);
        drive(20, 2);    chk("vblank_top", rgb_o, 12'h000);
        drive(20, 125);  chk("vblank_bottom", rgb_o, 12'h000);
        mode_i = 2'd2;
        check_pix("mid_frame_ignored", 0, 0, 12'hABC);
        chk("mid_frame_mode", {10'd0, mode_o}, 12'h000);
        drive(HMAX, VMAX - 1);
        drive(HMAX - 1, VMAX);
        chk("near_fb_mode", {10'd0, mode_o}, 12'h000);
        chk("near_fb_fs", {11'd0, frame_start_o}, 12'h000);
        fb();
        chk("fb_fs_high", {11'd0, frame_start_o}, 12'h001);
        chk("fb_mode_checker", {10'd0, mode_o}, 12'h002);
        drive(0, 0);
        chk("fs_one_cycle", {11'd0, frame_start_o}, 12'h000);
        chk("fs_blank_rgb", rgb_o, 12'h000);
        check_pix("next_frame_chk0", 0, 0, 12'h000);
        check_pix("next_frame_chk32", 32, 0, 12'hABC);
        cur_mode = 2;

        // Table-driven pattern vectors.
        for (int i = 0; i < 20; i++) begin
            if (int'(vecs[i].mode) != cur_mode) set_mode(int'(vecs[i].mode));
            color_i = vecs[i].color;
            check_pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp);
        end

        // Bouncing box: reflection on both axes.
        color_i = 12'h5A3;
        mode_i  = 2'd3;
        for (int i = 1; i <= 145; i++) begin
            fb();
            if (i == 104) begin
                check_pix("box104_in", 104, 104, 12'h5A3);
                check_pix("box104_above", 104, 103, 12'h000);
                check_pix("box104_right", 120, 104, 12'h000);
            end
            if (i == 105) begin
                check_pix("box105_in", 105, 103, 12'h5A3);
                check_pix("box105_below", 105, 119, 12'h000);
            end
            if (i == 144) begin
                check_pix("box144_in", 144, 64, 12'h5A3);
                check_pix("box144_left", 143, 64, 12'h000);
            end
        end
        check_pix("box145_in", 143, 63, 12'h5A3);
        check_pix("box145_right", 159, 63, 12'h000);
        check_pix("box145_left", 142, 63, 12'h000);

        // Freeze: this boundary still steps (mode was BOX), then five SOLID frames.
        set_mode(0);
        for (int i = 0; i < 5; i++) fb();
        set_mode(3);
        check_pix("freeze_in", 142, 62, 12'h5A3);
        check_pix("freeze_left", 141, 62, 12'h000);
        check_pix("freeze_above", 142, 61, 12'h000);

        // Asynchronous reset mid-line.
        check_pix("pre_reset", 142, 62, 12'h5A3);
        drive(HOFS + 143, VOFS + 62);
        #2;
        arstn = 1'b0;
        #1;
        chk("async_rgb", rgb_o, 12'h000);
        chk("async_mode", {10'd0, mode_o}, 12'h000);
        chk("async_fs", {11'd0, frame_start_o}, 12'h000);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        cur_mode = 0;
        set_mode(3);
        check_pix("post_rst_origin", 0, 0, 12'h5A3);
        check_pix("post_rst_right", 16, 0, 12'h000);
        check_pix("post_rst_below", 0, 16, 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Downstream pixel source for the VGA timing generator. Consumes that block's free-running `hcount`/`vcount` and produces the 12-bit RGB value for the DAC. Output is registered so it is aligned with the generator's registered `VGA_HS`/`VGA_VS`. One of four test patterns is shown, selected per frame; one pattern is a bouncing box animated once per frame.

## Interface

Parameters:
- `HSYNC_BITS`, 11, `hcount` width
- `VSYNC_BITS`, 11, `vcount` width
- `HD`, `HF`, `HR`, `HB`, default 1280/48/112/248; horizontal display, front porch, sync, back porch
- `VD`, `VF`, `VR`, `VB`, default 1024/1/3/38; vertical equivalents
- `BOX_SIZE`, 64, bouncing-box edge length in pixels; must be < HD and < VD

Ports:
- `clk`  in  1  pixel clock
- `arstn`  in  1  reset; **asynchronous, active-low**
- `hcount`  in  HSYNC_BITS  horizontal counter, 0..HMAX
- `vcount`  in  VSYNC_BITS  vertical counter, 0..VMAX
- `mode_i`  in  2  requested pattern
- `color_i`  in  12  foreground colour {R[3:0],G[3:0],B[3:0]}
- `rgb_o`  out  12  pixel colour; reset 12'h000
- `mode_o`  out  2  currently displayed pattern; reset 0
- `frame_start_o`  out  1  one-cycle pulse at frame boundary; reset 0

## Operation

- Derived constants:
  - HMAX = HD+HF+HR+HB-1; VMAX likewise.
  - HOFS = HR+HB; VOFS = VR+VB.
- Active region: HOFS ≤ hcount < HOFS+HD and VOFS ≤ vcount < VOFS+VD.
  - x = hcount-HOFS, y = vcount-VOFS, truncated to counter width.
  - Outside the active region rgb is 12'h000.
- Frame boundary (FB) is the cycle where hcount==HMAX and vcount==VMAX. At FB:
  - `mode_i` is latched into the mode register.
  - The box-position update runs.
  - `frame_start_o` is set for exactly one cycle.
  - `mode_i` changes at any other time have no effect.
- Mode 0, SOLID: active pixels show `color_i`. `color_i` is sampled live, not latched.
- Mode 1, BARS: 8 vertical bars, BAR_W = HD/8 (integer division).
  - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Bar index comes from a sequential pixel/bar counter pair, not a divider.
  - Counter pair clears when x==0 is presented.
  - Pixel counter wraps at BAR_W-1 and increments the bar index.
  - Index saturates at 7, so leftover HD%8 pixels show black.
- Mode 2, CHECKER: 32×32 squares. x[5]^y[5]==1 → `color_i`, else 000.
- Mode 3, BOX:
  - Inside box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE → `color_i`; elsewhere 000.
- Box mover state: box_x, box_y, dir_x, dir_y (1 = increasing).
  - Reset values: 0, 0, 1, 1.
  - Updated only at FB, and only when the latched mode (before FB) is 3. Otherwise frozen.
  - Per-axis rule, X shown; Y uses VD.
    - dir_x==1 and box_x==HD-BOX_SIZE → dir_x←0, box_x←box_x-1.
    - dir_x==0 and box_x==0 → dir_x←1, box_x←1.
    - Otherwise box_x moves ±1 per dir_x.
  - Position therefore always stays within 0..HD-BOX_SIZE.
- Reset mid-frame asynchronously clears all registers; operation resumes from the next counter values with mode 0.

## Timing

- Latency 1: `rgb_o` at edge n+1 reflects `hcount`/`vcount` sampled at edge n. This is the same alignment as the generator's registered syncs.
- `mode_o` and box position change on the edge that samples FB. The first pixel of the next frame uses the new values.
- `frame_start_o` is high during the cycle after FB (counters at 0,0).
- The BARS counter advances only on active-region cycles.

## Structure

- Package `vga_pkg`:
  - `pattern_e` enum: SOLID=0, BARS=1, CHECKER=2, BOX=3.
  - The 8 bar-colour localparams.
  - Default timing constants shared with the timing generator.
- Sub-module `vga_box_mover`:
  - Inputs: clk, arstn, step (FB && mode==BOX).
  - Outputs: box_x, box_y.
  - Parameterised by HD, VD, BOX_SIZE.
- Top level holds the active-region decode, bar counters, mode register and output mux/register.

## Test plan

Use small parameters: HD=160, HF=2, HR=4, HB=6, VD=120, VF=1, VR=2, VB=3, BOX_SIZE=16. Drive the counters from a reference counter model.

1. Reset: hold `arstn`=0 with counters running → `rgb_o`=000, `mode_o`=0, `frame_start_o`=0. Release → first active pixel (hcount=10, vcount=5) gives `rgb_o`=000 one cycle later until `color_i` is set.
2. SOLID with `color_i`=ABC:
   - `mode_i` moves 0→2 mid-frame → rest of frame stays SOLID.
   - Next frame's first pixel is CHECKER.
   - `frame_start_o` is one cycle high at (0,0).
   - Blanking pixels read 000.
3. BARS: x=0 → FFF; x=19 → FFF; x=20 → FF0; x=79 → 0F0; x=159 → 000. The pattern repeats identically on every line.
4. CHECKER with `color_i`=0F0: (x,y)=(0,0) → 000; (32,0) → 0F0; (32,32) → 000; (0,32) → 0F0.
5. BOX:
   - After 144 BOX frames → box_x=144, dir_x flips; next frame box_x=143.
   - After 104 frames → box_y=104, flips likewise.
   - Pixel (box_x, box_y) = `color_i`; (box_x+16, box_y) = 000.
6. Freeze/reset:
   - Switch to mode 0 for 5 frames then back to 3 → position unchanged.
   - Assert `arstn` mid-line → all outputs 000/0 within the same cycle, box returns to (0,0).
